// File: rtl/storage_bridge_wb_pl_if.sv
// Shared Wishbone bus bundle for the storage bridge: one address/data path,
// two slave channels selected by per-channel strobe, ack and err bits.
interface storage_bridge_wb_pl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic [1:0]  wb_stb_i;
  logic [1:0]  wb_ack_o;
  logic [1:0]  wb_err_o;
  logic [31:0] wb_rw_dat_o;
  logic [31:0] wb_ro_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_err_o, wb_rw_dat_o, wb_ro_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_err_o, wb_rw_dat_o, wb_ro_dat_o
  );
endinterface

// File: rtl/storage_bridge_wb_pl.sv
// Wishbone-to-SRAM bridge: ch0 read/write on the SRAM rw port, ch1 read-only on the r port.
// Define STORAGE_BRIDGE_ERR_EN to answer unmapped accesses with wb_err_o instead of wb_ack_o.
module storage_bridge_wb_pl #(
  parameter int                      RW_BLOCKS     = 2,
  parameter int                      RO_BLOCKS     = 1,
  parameter int                      ADDR_W        = 8,
  parameter logic [7:0]              BASE_ADR      = 8'h01,
  parameter logic [RW_BLOCKS*24-1:0] RW_BLOCKS_ADR = {24'h10_0000, 24'h00_0000},
  parameter logic [RO_BLOCKS*24-1:0] RO_BLOCKS_ADR = 24'h20_0000,
  parameter int                      RD_LATENCY    = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  storage_bridge_wb_pl_if.slave    bus,
  output logic [RW_BLOCKS-1:0]     mgmt_ena,
  output logic [RW_BLOCKS-1:0]     mgmt_wen,
  output logic [RW_BLOCKS*4-1:0]   mgmt_wen_mask,
  output logic [ADDR_W-1:0]        mgmt_addr,
  output logic [31:0]              mgmt_wdata,
  input  logic [RW_BLOCKS*32-1:0]  mgmt_rdata,
  output logic [RO_BLOCKS-1:0]     mgmt_ena_ro,
  output logic [ADDR_W-1:0]        mgmt_addr_ro,
  input  logic [RO_BLOCKS*32-1:0]  mgmt_rdata_ro
);
  localparam int TAG_LO = ADDR_W + 2;
  localparam int TAG_W  = 22 - ADDR_W;
  // Last WAIT count value; WAIT lasts RD_LATENCY-1 cycles.
  localparam logic [1:0] WAIT_LAST = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_DONE} state_t;

  logic [1:0]             dec_hit;
  logic [1:0][2:0]        dec_blk;
  logic                   base_ok;
  logic [1:0]             issue_vec, hit_vec, we_vec, ack_vec;
  logic [1:0][2:0]        blk_arr;
  logic [1:0][ADDR_W-1:0] addr_arr;
  logic [1:0][31:0]       wdata_arr, dat_arr, rdata_sel;
  logic [1:0][3:0]        sel_arr;
`ifdef STORAGE_BRIDGE_ERR_EN
  logic [1:0]             err_vec;
`endif
  logic                   unused_sig;

  // Descending scan so the lowest-index matching block wins.
  always_comb begin
    dec_hit = '0;
    dec_blk = '0;
    base_ok = (bus.wb_adr_i[31:24] == BASE_ADR);
    for (int b = RW_BLOCKS - 1; b >= 0; b--) begin
      if (base_ok && bus.wb_adr_i[23:TAG_LO] == RW_BLOCKS_ADR[24*b+TAG_LO +: TAG_W]) begin
        dec_hit[0] = 1'b1;
        dec_blk[0] = 3'(b);
      end
    end
    for (int b = RO_BLOCKS - 1; b >= 0; b--) begin
      if (base_ok && !bus.wb_we_i &&
          bus.wb_adr_i[23:TAG_LO] == RO_BLOCKS_ADR[24*b+TAG_LO +: TAG_W]) begin
        dec_hit[1] = 1'b1;
        dec_blk[1] = 3'(b);
      end
    end
  end

  always_comb begin
    rdata_sel = '0;
    for (int b = 0; b < RW_BLOCKS; b++)
      if (blk_arr[0] == 3'(b)) rdata_sel[0] = mgmt_rdata[32*b +: 32];
    for (int b = 0; b < RO_BLOCKS; b++)
      if (blk_arr[1] == 3'(b)) rdata_sel[1] = mgmt_rdata_ro[32*b +: 32];
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       dat_reg, dat_next;
    logic [3:0]        sel_reg, sel_next;
    logic [2:0]        blk_reg, blk_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic              hit_reg, hit_next;
    logic              ack_reg, ack_next;
`ifdef STORAGE_BRIDGE_ERR_EN
    logic              err_reg, err_next;
`endif

    always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      dat_next   = dat_reg;
      sel_next   = sel_reg;
      blk_next   = blk_reg;
      cnt_next   = cnt_reg;
      we_next    = we_reg;
      hit_next   = hit_reg;
      ack_next   = 1'b0;
`ifdef STORAGE_BRIDGE_ERR_EN
      err_next   = 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (bus.wb_cyc_i && bus.wb_stb_i[gi]) begin
            addr_next  = bus.wb_adr_i[ADDR_W+1:2];
            wdata_next = bus.wb_dat_i;
            sel_next   = bus.wb_sel_i;
            we_next    = bus.wb_we_i;
            hit_next   = dec_hit[gi];
            blk_next   = dec_blk[gi];
            cnt_next   = 2'd0;
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.wb_cyc_i)                     state_next = ST_IDLE;
          else if (we_reg || RD_LATENCY == 1)    state_next = ST_RESP;
          else                                   state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.wb_cyc_i)                state_next = ST_IDLE;
          else if (cnt_reg == WAIT_LAST)    state_next = ST_RESP;
          else                              cnt_next = cnt_reg + 2'd1;
        end
        ST_RESP: begin
          if (!bus.wb_cyc_i) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DONE;
            if (!we_reg) dat_next = hit_reg ? rdata_sel[gi] : 32'h0;
            if (hit_reg) begin
              ack_next = 1'b1;
            end else begin
`ifdef STORAGE_BRIDGE_ERR_EN
              err_next = 1'b1;
`else
              ack_next = 1'b1;
`endif
            end
          end
        end
        ST_DONE: begin
          if (!bus.wb_stb_i[gi]) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        state_reg <= ST_IDLE;
        addr_reg  <= '0;
        wdata_reg <= '0;
        dat_reg   <= '0;
        sel_reg   <= '0;
        blk_reg   <= '0;
        cnt_reg   <= '0;
        we_reg    <= 1'b0;
        hit_reg   <= 1'b0;
        ack_reg   <= 1'b0;
`ifdef STORAGE_BRIDGE_ERR_EN
        err_reg   <= 1'b0;
`endif
      end else begin
        state_reg <= state_next;
        addr_reg  <= addr_next;
        wdata_reg <= wdata_next;
        dat_reg   <= dat_next;
        sel_reg   <= sel_next;
        blk_reg   <= blk_next;
        cnt_reg   <= cnt_next;
        we_reg    <= we_next;
        hit_reg   <= hit_next;
        ack_reg   <= ack_next;
`ifdef STORAGE_BRIDGE_ERR_EN
        err_reg   <= err_next;
`endif
      end
    end

    assign issue_vec[gi] = (state_reg == ST_ISSUE);
    assign hit_vec[gi]   = hit_reg;
    assign we_vec[gi]    = we_reg;
    assign ack_vec[gi]   = ack_reg;
    assign blk_arr[gi]   = blk_reg;
    assign addr_arr[gi]  = addr_reg;
    assign wdata_arr[gi] = wdata_reg;
    assign sel_arr[gi]   = sel_reg;
    assign dat_arr[gi]   = dat_reg;
`ifdef STORAGE_BRIDGE_ERR_EN
    assign err_vec[gi]   = err_reg;
`endif
  end

  // SRAM strobes exist only during ISSUE, so they are single-cycle by construction.
  always_comb begin
    mgmt_ena      = '0;
    mgmt_wen      = '0;
    mgmt_wen_mask = '0;
    mgmt_addr     = '0;
    mgmt_wdata    = '0;
    mgmt_ena_ro   = '0;
    mgmt_addr_ro  = '0;
    if (issue_vec[0]) begin
      mgmt_addr  = addr_arr[0];
      mgmt_wdata = wdata_arr[0];
      for (int b = 0; b < RW_BLOCKS; b++) begin
        if (hit_vec[0] && blk_arr[0] == 3'(b)) begin
          mgmt_ena[b]            = 1'b1;
          mgmt_wen[b]            = we_vec[0];
          mgmt_wen_mask[4*b +: 4] = sel_arr[0];
        end
      end
    end
    if (issue_vec[1]) begin
      mgmt_addr_ro = addr_arr[1];
      for (int b = 0; b < RO_BLOCKS; b++)
        if (hit_vec[1] && blk_arr[1] == 3'(b)) mgmt_ena_ro[b] = 1'b1;
    end
  end

  assign bus.wb_ack_o    = ack_vec;
  assign bus.wb_rw_dat_o = dat_arr[0];
  assign bus.wb_ro_dat_o = dat_arr[1];
`ifdef STORAGE_BRIDGE_ERR_EN
  assign bus.wb_err_o    = err_vec;
`else
  assign bus.wb_err_o    = 2'b00;
`endif

  assign unused_sig = &{1'b0, bus.wb_adr_i[1:0], wdata_arr[1], sel_arr[1], we_vec[1]};
endmodule

// File: tb/tb_storage_bridge_wb_pl.sv
// Directed bench for storage_bridge_wb_pl: dut_a uses RD_LATENCY=1 with a 2-block SRAM model,
// dut_b uses RD_LATENCY=3 for latency, lingering-stb and mid-transfer reset checks.
module tb_storage_bridge_wb_pl;
`ifdef STORAGE_BRIDGE_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  storage_bridge_wb_pl_if bus_a ();
  storage_bridge_wb_pl_if bus_b ();

  logic [1:0]  ena_a, wen_a, ena_b, wen_b;
  logic [7:0]  mask_a, mask_b, addr_a, addr_b, addr_ro_a, addr_ro_b;
  logic [31:0] wdata_a, wdata_b, rdata_ro_a, rdata_ro_b;
  logic [63:0] rdata_a, rdata_b;
  logic [0:0]  ena_ro_a, ena_ro_b;

  storage_bridge_wb_pl u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .bus(bus_a),
    .mgmt_ena(ena_a), .mgmt_wen(wen_a), .mgmt_wen_mask(mask_a), .mgmt_addr(addr_a),
    .mgmt_wdata(wdata_a), .mgmt_rdata(rdata_a), .mgmt_ena_ro(ena_ro_a),
    .mgmt_addr_ro(addr_ro_a), .mgmt_rdata_ro(rdata_ro_a)
  );

  storage_bridge_wb_pl #(.RD_LATENCY(3)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .bus(bus_b),
    .mgmt_ena(ena_b), .mgmt_wen(wen_b), .mgmt_wen_mask(mask_b), .mgmt_addr(addr_b),
    .mgmt_wdata(wdata_b), .mgmt_rdata(rdata_b), .mgmt_ena_ro(ena_ro_b),
    .mgmt_addr_ro(addr_ro_b), .mgmt_rdata_ro(rdata_ro_b)
  );

  // SRAM model A: 1-cycle read latency, rdata valid for one cycle only.
  logic [31:0] mem_a [2][256];
  int ena_cnt_a = 0, ena_ro_cnt_a = 0;
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      rdata_a[32*b +: 32] <= 32'hBAD0_BAD0;
      if (ena_a[b]) begin
        if (wen_a[b]) begin
          for (int k = 0; k < 4; k++)
            if (mask_a[4*b+k]) mem_a[b][addr_a][8*k +: 8] <= wdata_a[8*k +: 8];
        end else begin
          rdata_a[32*b +: 32] <= mem_a[b][addr_a];
        end
      end
    end
    rdata_ro_a <= ena_ro_a[0] ? mem_a[0][addr_ro_a] : 32'hBAD0_BAD0;
    if (|ena_a)    ena_cnt_a    <= ena_cnt_a + 1;
    if (|ena_ro_a) ena_ro_cnt_a <= ena_ro_cnt_a + 1;
  end

  // SRAM model B: read-only block 0 with a 3-stage read pipeline.
  logic [31:0] mem_b [256];
  logic [31:0] pipe_b [3];
  int ena_cnt_b = 0, ack_cnt_b = 0;
  always @(posedge clk) begin
    pipe_b[0] <= (ena_b[0] && !wen_b[0]) ? mem_b[addr_b] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (|ena_b)             ena_cnt_b <= ena_cnt_b + 1;
    if (bus_b.wb_ack_o[0])  ack_cnt_b <= ack_cnt_b + 1;
  end
  assign rdata_b    = {32'hBAD0_0001, pipe_b[2]};
  assign rdata_ro_b = 32'h0;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle_a();
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 2'b00; bus_a.wb_we_i = 1'b0;
    bus_a.wb_adr_i = '0;   bus_a.wb_dat_i = '0;    bus_a.wb_sel_i = 4'h0;
  endtask

  task automatic bus_idle_b();
    bus_b.wb_cyc_i = 1'b0; bus_b.wb_stb_i = 2'b00; bus_b.wb_we_i = 1'b0;
    bus_b.wb_adr_i = '0;   bus_b.wb_dat_i = '0;    bus_b.wb_sel_i = 4'h0;
  endtask

  // One bus transaction on dut_a; lat counts edges after the edge that samples stb.
  task automatic xfer_a(input logic [1:0] stb, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [1:0] acks, output logic [1:0] errs, output int lat);
    bit done = 1'b0;
    acks = 2'b00; errs = 2'b00; lat = -1;
    bus_a.wb_cyc_i = 1'b1; bus_a.wb_stb_i = stb; bus_a.wb_we_i = we;
    bus_a.wb_adr_i = adr;  bus_a.wb_dat_i = dat; bus_a.wb_sel_i = sel;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(posedge clk); #1;
      acks |= bus_a.wb_ack_o;
      errs |= bus_a.wb_err_o;
      if ((acks | errs) == stb) begin
        lat = n - 1;
        done = 1'b1;
      end
    end
    check_eq("resp_seen", 32'(acks | errs), 32'(stb));
    bus_idle_a();
    @(posedge clk); #1;
    check_eq("resp_pulse", 32'({bus_a.wb_ack_o, bus_a.wb_err_o}), 32'h0);
    $display("xfer_a stb=%b we=%0d adr=%h dat=%h sel=%h ack=%b err=%b lat=%0d rw=%h ro=%h",
             stb, we, adr, dat, sel, acks, errs, lat, bus_a.wb_rw_dat_o, bus_a.wb_ro_dat_o);
  endtask

  task automatic read_b(input logic [31:0] adr, output int lat);
    bit done = 1'b0;
    lat = -1;
    bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 2'b01; bus_b.wb_we_i = 1'b0;
    bus_b.wb_adr_i = adr;  bus_b.wb_sel_i = 4'hF;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(posedge clk); #1;
      if (bus_b.wb_ack_o[0]) begin
        lat = n - 1;
        done = 1'b1;
      end
    end
    check_eq("b_resp_seen", 32'(done), 32'd1);
    bus_idle_b();
    @(posedge clk); #1;
    $display("read_b adr=%h lat=%0d rw=%h", adr, lat, bus_b.wb_rw_dat_o);
  endtask

  logic [31:0] exp_a [2][100];
  logic [1:0]  acks, errs;
  int          lat, snap0, snap1, acks_seen;
  logic [31:0] adr, data;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_idle_a(); bus_idle_b();
    for (int i = 0; i < 256; i++) mem_b[i] = 32'h0;
    mem_b[4] = 32'h1234_5678;
    mem_b[9] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    check_eq("rst_ack",   32'(bus_a.wb_ack_o), 32'h0);
    check_eq("rst_err",   32'(bus_a.wb_err_o), 32'h0);
    check_eq("rst_rwdat", bus_a.wb_rw_dat_o,   32'h0);
    check_eq("rst_rodat", bus_a.wb_ro_dat_o,   32'h0);
    check_eq("rst_ena",   32'({ena_a, ena_ro_a}), 32'h0);

    // Fill both RW blocks through ch0, then read everything back.
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 100; j++) begin
        data = $urandom;
        exp_a[b][j] = data;
        adr = 32'h0100_0000 + (b == 1 ? 32'h0010_0000 : 32'h0) + 32'(4 * j);
        xfer_a(2'b01, 1'b1, adr, data, 4'hF, acks, errs, lat);
        check_eq("wr_ack", 32'(acks), 32'h1);
        check_eq("wr_lat", 32'(lat),  32'd2);
      end
    end
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 100; j++) begin
        adr = 32'h0100_0000 + (b == 1 ? 32'h0010_0000 : 32'h0) + 32'(4 * j);
        xfer_a(2'b01, 1'b0, adr, 32'h0, 4'hF, acks, errs, lat);
        check_eq("rd_data", bus_a.wb_rw_dat_o, exp_a[b][j]);
        check_eq("rd_lat",  32'(lat), 32'd2);
      end
    end

    // Block 0 again, through the read-only port.
    for (int j = 0; j < 100; j++) begin
      xfer_a(2'b10, 1'b0, 32'h0120_0000 + 32'(4 * j), 32'h0, 4'hF, acks, errs, lat);
      check_eq("ro_data", bus_a.wb_ro_dat_o, exp_a[0][j]);
      check_eq("ro_ack",  32'(acks), 32'h2);
    end

    // Both channels start together; the shared address misses the rw map.
    xfer_a(2'b11, 1'b0, 32'h0120_001C, 32'h0, 4'hF, acks, errs, lat);
    check_eq("dual_ack",   32'(acks), ERR_MODE ? 32'h2 : 32'h3);
    check_eq("dual_err",   32'(errs), ERR_MODE ? 32'h1 : 32'h0);
    check_eq("dual_lat",   32'(lat),  32'd2);
    check_eq("dual_ro",    bus_a.wb_ro_dat_o, exp_a[0][7]);
    check_eq("dual_rw",    bus_a.wb_rw_dat_o, 32'h0);

    // Byte-lane write.
    xfer_a(2'b01, 1'b1, 32'h0100_0000, 32'h0, 4'hF, acks, errs, lat);
    xfer_a(2'b01, 1'b1, 32'h0100_0000, 32'hAABB_CCDD, 4'b0101, acks, errs, lat);
    xfer_a(2'b01, 1'b0, 32'h0100_0000, 32'h0, 4'hF, acks, errs, lat);
    check_eq("sel_data", bus_a.wb_rw_dat_o, 32'h00BB_00DD);

    // Unmapped accesses: bad base on ch0, write on ch1.
    snap0 = ena_cnt_a; snap1 = ena_ro_cnt_a;
    xfer_a(2'b01, 1'b0, 32'h0230_0000, 32'h0, 4'hF, acks, errs, lat);
    check_eq("bad_ack",  32'(acks), ERR_MODE ? 32'h0 : 32'h1);
    check_eq("bad_err",  32'(errs), ERR_MODE ? 32'h1 : 32'h0);
    check_eq("bad_lat",  32'(lat),  32'd2);
    check_eq("bad_data", bus_a.wb_rw_dat_o, 32'h0);
    xfer_a(2'b10, 1'b1, 32'h0120_0000, 32'h5555_AAAA, 4'hF, acks, errs, lat);
    check_eq("rowr_ack", 32'(acks), ERR_MODE ? 32'h0 : 32'h2);
    check_eq("rowr_err", 32'(errs), ERR_MODE ? 32'h2 : 32'h0);
    check_eq("bad_ena",    32'(ena_cnt_a - snap0),    32'd0);
    check_eq("bad_ena_ro", 32'(ena_ro_cnt_a - snap1), 32'd0);

    // RD_LATENCY=3 with stb held well past the ack.
    snap0 = ena_cnt_b; snap1 = ack_cnt_b;
    acks_seen = 0; lat = -1;
    bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 2'b01; bus_b.wb_we_i = 1'b0;
    bus_b.wb_adr_i = 32'h0100_0010; bus_b.wb_sel_i = 4'hF;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bus_b.wb_ack_o[0]) begin
        acks_seen++;
        if (lat < 0) lat = n - 1;
      end
    end
    bus_idle_b();
    @(posedge clk); #1;
    $display("hold_b adr=01000010 acks=%0d lat=%0d rw=%h", acks_seen, lat, bus_b.wb_rw_dat_o);
    check_eq("l3_lat",   32'(lat),       32'd4);
    check_eq("l3_acks",  32'(acks_seen), 32'd1);
    check_eq("l3_data",  bus_b.wb_rw_dat_o, 32'h1234_5678);
    check_eq("l3_ena",   32'(ena_cnt_b - snap0), 32'd1);

    // Reset while the read sits in WAIT.
    snap1 = ack_cnt_b;
    bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 2'b01; bus_b.wb_we_i = 1'b0;
    bus_b.wb_adr_i = 32'h0100_0010; bus_b.wb_sel_i = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_eq("wrst_ack",   32'(bus_b.wb_ack_o), 32'h0);
    check_eq("wrst_err",   32'(bus_b.wb_err_o), 32'h0);
    check_eq("wrst_rwdat", bus_b.wb_rw_dat_o,   32'h0);
    check_eq("wrst_ena",   32'({ena_b, wen_b, mask_b}), 32'h0);
    check_eq("wrst_addr",  32'({addr_b, addr_ro_b}),    32'h0);
    check_eq("wrst_wdata", wdata_b, 32'h0);
    rst_b = 1'b0;
    bus_idle_b();
    repeat (6) @(posedge clk);
    #1;
    check_eq("wrst_noack", 32'(ack_cnt_b - snap1), 32'd0);
    read_b(32'h0100_0024, lat);
    check_eq("post_rst_lat",  32'(lat), 32'd4);
    check_eq("post_rst_data", bus_b.wb_rw_dat_o, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
